// File: rtl/fifo_flag_ctrl.sv
// FIFO status side: tracks occupancy from the write/read fire strobes and
// returns registered full/empty, almost flags, sticky error flags and a pointer check.
module fifo_flag_ctrl #(
  parameter int OSTD_NUM   = 8,
  parameter int PTR_SIZE   = 3,
  parameter int AFULL_THR  = 6,
  parameter int AEMPTY_THR = 2
) (
  input  logic                clk_in,
  input  logic                sreset,
  input  logic                wr_req,
  input  logic                rd_req,
  input  logic                wr_fire,
  input  logic                rd_fire,
  input  logic [PTR_SIZE-1:0] wr_ptr,
  input  logic [PTR_SIZE-1:0] rd_ptr,
  input  logic                err_clr,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [PTR_SIZE:0]   fill_level,
  output logic                overflow_err,
  output logic                underflow_err,
  output logic                ptr_mismatch
);

  localparam logic [PTR_SIZE:0] FULL_LVL   = (PTR_SIZE+1)'(OSTD_NUM);
  localparam logic [PTR_SIZE:0] AFULL_LVL  = (PTR_SIZE+1)'(AFULL_THR);
  localparam logic [PTR_SIZE:0] AEMPTY_LVL = (PTR_SIZE+1)'(AEMPTY_THR);
  localparam logic [PTR_SIZE:0] ONE        = (PTR_SIZE+1)'(1);

  logic [PTR_SIZE:0]   fill_next;
  logic [PTR_SIZE-1:0] ptr_diff;
  logic                ovf_set;
  logic                unf_set;
  logic                mis_set;

  // Simultaneous fires cancel; a lone fire is ignored at the saturating end.
  always_comb begin
    fill_next = fill_level;
    if (wr_fire && !rd_fire && (fill_level != FULL_LVL))
      fill_next = fill_level + ONE;
    else if (rd_fire && !wr_fire && (fill_level != '0))
      fill_next = fill_level - ONE;
  end

  assign ptr_diff = wr_ptr - rd_ptr;
  assign ovf_set  = (wr_req | wr_fire) & full;
  assign unf_set  = (rd_req | rd_fire) & empty;
  assign mis_set  = (ptr_diff != fill_level[PTR_SIZE-1:0]);

  always_ff @(posedge clk_in) begin
    if (sreset) begin
      fill_level    <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      ptr_mismatch  <= 1'b0;
    end else begin
      fill_level    <= fill_next;
      full          <= (fill_next == FULL_LVL);
      empty         <= (fill_next == '0);
      almost_full   <= (fill_next >= AFULL_LVL);
      almost_empty  <= (fill_next <= AEMPTY_LVL);
      // A set condition in the clear cycle wins over err_clr.
      overflow_err  <= ovf_set | (overflow_err  & ~err_clr);
      underflow_err <= unf_set | (underflow_err & ~err_clr);
      ptr_mismatch  <= mis_set | (ptr_mismatch  & ~err_clr);
    end
  end

endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// Bench for fifo_flag_ctrl: directed scenarios followed by random traffic,
// each cycle compared against an integer occupancy model.
module tb_fifo_flag_ctrl;

  localparam int N    = 8;
  localparam int P    = 3;
  localparam int AF   = 6;
  localparam int AE   = 2;

  logic         clk_in = 1'b0;
  logic         sreset = 1'b1;
  logic         wr_req = 1'b0, rd_req = 1'b0, wr_fire = 1'b0, rd_fire = 1'b0;
  logic [P-1:0] wr_ptr = '0, rd_ptr = '0;
  logic         err_clr = 1'b0;
  logic         full, empty, almost_full, almost_empty;
  logic [P:0]   fill_level;
  logic         overflow_err, underflow_err, ptr_mismatch;

  int n_checks = 0;
  int n_fail   = 0;

  int m_fill = 0;
  bit m_ovf = 0, m_unf = 0, m_mis = 0;
  int m_wp = 0, m_rp = 0;

  fifo_flag_ctrl #(.OSTD_NUM(N), .PTR_SIZE(P), .AFULL_THR(AF), .AEMPTY_THR(AE)) dut (
    .clk_in(clk_in), .sreset(sreset), .wr_req(wr_req), .rd_req(rd_req),
    .wr_fire(wr_fire), .rd_fire(rd_fire), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .err_clr(err_clr), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .fill_level(fill_level),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .ptr_mismatch(ptr_mismatch)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " fill_level"},    int'(fill_level),    m_fill);
    chk({tag, " full"},          int'(full),          int'(m_fill == N));
    chk({tag, " empty"},         int'(empty),         int'(m_fill == 0));
    chk({tag, " almost_full"},   int'(almost_full),   int'(m_fill >= AF));
    chk({tag, " almost_empty"},  int'(almost_empty),  int'(m_fill <= AE));
    chk({tag, " overflow_err"},  int'(overflow_err),  int'(m_ovf));
    chk({tag, " underflow_err"}, int'(underflow_err), int'(m_unf));
    chk({tag, " ptr_mismatch"},  int'(ptr_mismatch),  int'(m_mis));
  endtask

  // One clock: drive inputs, let the edge happen, advance model and pointers, check.
  task automatic step(input string tag, input bit wq, input bit rq, input bit wf,
                      input bit rf, input bit clr, input bit rst);
    int  nf;
    bit  ov, un, mm, wadv, radv;
    wr_req = wq; rd_req = rq; wr_fire = wf; rd_fire = rf; err_clr = clr; sreset = rst;
    ov   = (wq || wf) && (m_fill == N);
    un   = (rq || rf) && (m_fill == 0);
    mm   = (((m_wp - m_rp) % N + N) % N) != (m_fill % N);
    nf   = m_fill;
    if (wf && !rf && m_fill < N) nf = m_fill + 1;
    if (rf && !wf && m_fill > 0) nf = m_fill - 1;
    wadv = wf && (m_fill < N || rf);
    radv = rf && (m_fill > 0 || wf);
    @(posedge clk_in);
    if (rst) begin
      m_fill = 0; m_ovf = 0; m_unf = 0; m_mis = 0; m_wp = 0; m_rp = 0;
    end else begin
      m_fill = nf;
      m_ovf  = ov | (m_ovf & !clr);
      m_unf  = un | (m_unf & !clr);
      m_mis  = mm | (m_mis & !clr);
      if (wadv) m_wp = (m_wp + 1) % N;
      if (radv) m_rp = (m_rp + 1) % N;
    end
    #1;
    wr_ptr = P'(m_wp);
    rd_ptr = P'(m_rp);
    @(negedge clk_in);
    check_all(tag);
  endtask

  initial begin
    // T1 reset
    step("T1 rst0", 0, 0, 0, 0, 0, 1);
    step("T1 rst1", 0, 0, 0, 0, 0, 1);
    step("T1 idle", 0, 0, 0, 0, 0, 0);
    chk("T1 reset empty", int'(empty), 1);
    chk("T1 reset almost_empty", int'(almost_empty), 1);

    // T2 fill to full
    for (int i = 1; i <= N; i++) begin
      step("T2 fill", 1, 0, 1, 0, 0, 0);
      chk("T2 fill_level", int'(fill_level), i);
    end
    chk("T2 full", int'(full), 1);

    // T3 overflow via wr_req only, then clear
    step("T3 ovf", 1, 0, 0, 0, 0, 0);
    chk("T3 overflow set", int'(overflow_err), 1);
    step("T3 hold", 0, 0, 0, 0, 0, 0);
    chk("T3 overflow sticky", int'(overflow_err), 1);
    step("T3 clr", 0, 0, 0, 0, 1, 0);
    chk("T3 overflow cleared", int'(overflow_err), 0);

    // both fires while full: fill holds at N, overflow sets
    step("B both@full", 1, 1, 1, 1, 0, 0);
    chk("B fill at full", int'(fill_level), N);
    chk("B overflow", int'(overflow_err), 1);
    step("B clr", 0, 0, 0, 0, 1, 0);

    // T4 simultaneous fires at fill 4, wrapping pointers
    for (int i = 0; i < 4; i++) step("T4 drain", 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("T4 both", 1, 1, 1, 1, 0, 0);
    chk("T4 fill", int'(fill_level), 4);
    chk("T4 no mismatch", int'(ptr_mismatch), 0);

    // T5 refill then drain to empty, then underflow
    for (int i = 0; i < 4; i++) step("T5 fill", 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) step("T5 drain", 0, 1, 0, 1, 0, 0);
    chk("T5 empty", int'(empty), 1);
    step("T5 unf", 0, 1, 0, 0, 0, 0);
    chk("T5 underflow", int'(underflow_err), 1);
    // set wins over clear in the same cycle
    step("T5 set+clr", 0, 1, 0, 0, 1, 0);
    chk("T5 set beats clr", int'(underflow_err), 1);
    step("T5 clr", 0, 0, 0, 0, 1, 0);
    chk("T5 cleared", int'(underflow_err), 0);

    // T6 reset mid-operation, then forced pointer mismatch
    for (int i = 0; i < 5; i++) step("T6 fill", 1, 0, 1, 0, 0, 0);
    step("T6 ovf", 1, 0, 0, 0, 0, 0);
    step("T6 rst", 1, 0, 1, 0, 0, 1);
    chk("T6 fill after rst", int'(fill_level), 0);
    chk("T6 ovf after rst", int'(overflow_err), 0);
    m_wp = 3; m_rp = 0;
    wr_ptr = 3'd3; rd_ptr = 3'd0;
    step("T6 mismatch", 0, 0, 0, 0, 0, 0);
    chk("T6 ptr_mismatch", int'(ptr_mismatch), 1);
    step("T6 rst2", 0, 0, 0, 0, 0, 1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit wf, rf;
      wf = ($urandom_range(0, 99) < 50);
      rf = ($urandom_range(0, 99) < 45);
      step("RND", wf | ($urandom_range(0, 9) == 0), rf | ($urandom_range(0, 9) == 0),
           wf, rf, ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
